// File: rtl/ram_rmw_ctrl.sv
// ram_rmw_ctrl: serialising initiator for a dual-port RAM with 1-cycle registered read.
// Full-word writes go straight through; partial-byte writes become read-modify-write.
module ram_rmw_ctrl #(
    parameter int DATA_W    = 32,
    parameter int NUM_WORDS = 256,
    parameter int ADDR_W    = $clog2(NUM_WORDS),
    parameter int BE_W      = DATA_W / 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic [BE_W-1:0]   req_be,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic [ADDR_W-1:0] mem_rdaddr,
    output logic              mem_rden,
    output logic [ADDR_W-1:0] mem_wraddr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_wren,
    input  logic [DATA_W-1:0] mem_rdata
);
    typedef enum logic [1:0] {IDLE, RD_WAIT, RMW_MERGE} state_t;
    state_t            state, state_n;
    logic [ADDR_W-1:0] lat_addr;
    logic [DATA_W-1:0] lat_wdata, merged;
    logic [BE_W-1:0]   lat_be;
    logic              lat_en;
    for (genvar b = 0; b < BE_W; b++) begin : g_merge
        assign merged[8*b +: 8] = lat_be[b] ? lat_wdata[8*b +: 8] : mem_rdata[8*b +: 8];
    end
    // Both plain reads and partial writes start with a RAM read; only the latter latch the request.
    always_comb begin
        state_n    = state;
        req_ready  = 1'b0;
        mem_rden   = 1'b0;
        mem_rdaddr = '0;
        mem_wren   = 1'b0;
        mem_wraddr = '0;
        mem_wdata  = '0;
        lat_en     = 1'b0;
        case (state)
            IDLE: begin
                req_ready = !rst;
                if (req_valid && !rst) begin
                    if (!req_we || ((~&req_be) && (|req_be))) begin
                        mem_rden   = 1'b1;
                        mem_rdaddr = req_addr;
                        lat_en     = req_we;
                        state_n    = req_we ? RMW_MERGE : RD_WAIT;
                    end else if (&req_be) begin
                        mem_wren   = 1'b1;
                        mem_wraddr = req_addr;
                        mem_wdata  = req_wdata;
                    end
                end
            end
            RD_WAIT: state_n = IDLE;
            RMW_MERGE: begin
                if (!rst) begin
                    mem_wren   = 1'b1;
                    mem_wraddr = lat_addr;
                    mem_wdata  = merged;
                end
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            lat_be    <= '0;
        end else begin
            state     <= state_n;
            rsp_valid <= state == RD_WAIT;
            if (state == RD_WAIT) rsp_rdata <= mem_rdata;
            if (lat_en) begin
                lat_addr  <= req_addr;
                lat_wdata <= req_wdata;
                lat_be    <= req_be;
            end
        end
    end
endmodule

// File: tb/tb_ram_rmw_ctrl.sv
// tb_ram_rmw_ctrl: directed and random requests against a transaction-level memory model
// that predicts per-cycle handshake, RAM port activity and responses.
module tb_ram_rmw_ctrl;
    localparam int DW = 32;
    localparam int AW = 8;
    localparam int BW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          req_valid = 1'b0, req_we = 1'b0;
    logic [AW-1:0] req_addr = '0;
    logic [DW-1:0] req_wdata = '0;
    logic [BW-1:0] req_be = '0;
    logic          req_ready, rsp_valid, mem_rden, mem_wren;
    logic [DW-1:0] rsp_rdata, mem_wdata;
    logic [DW-1:0] mem_rdata = '0;
    logic [AW-1:0] mem_rdaddr, mem_wraddr;

    ram_rmw_ctrl dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be), .rsp_valid(rsp_valid),
        .rsp_rdata(rsp_rdata), .mem_rdaddr(mem_rdaddr), .mem_rden(mem_rden),
        .mem_wraddr(mem_wraddr), .mem_wdata(mem_wdata), .mem_wren(mem_wren), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] init_val(input int i);
        return (i == 3) ? 32'h0 : (i == 7) ? 32'h11223344 : (i == 9) ? 32'h0BADF00D :
               (32'h9E3779B9 * (i + 1)) ^ 32'h5A5A_A5A5;
    endfunction

    function automatic logic [DW-1:0] merge(input logic [DW-1:0] old, input logic [DW-1:0] nw,
                                            input logic [BW-1:0] be);
        logic [DW-1:0] mask;
        mask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
        return (old & ~mask) | (nw & mask);
    endfunction

    // Attached RAM: registered read, write on the clock edge.
    logic [DW-1:0] ram [256];
    initial begin
        for (int i = 0; i < 256; i++) ram[i] = init_val(i);
        forever @(posedge clk) begin
            if (mem_rden) mem_rdata <= ram[mem_rdaddr];
            if (mem_wren) ram[mem_wraddr] <= mem_wdata;
        end
    end

    // Reference model and per-cycle comparison, evaluated mid-cycle.
    logic [DW-1:0] gold [256];
    int            cyc = 0, busy_until = 0, wr_due = -1;
    logic [AW-1:0] p_addr;
    logic [DW-1:0] p_old, held = '0;
    logic [DW-1:0] rsp_q[$];
    int            due_q[$];
    int            wren_cnt = 0, rden_cnt = 0, rsp_cnt = 0;
    logic [DW-1:0] cap_wdata = '0, cap_rsp = '0;
    initial begin
        logic          e_ready, e_rden, e_wren, e_rsp;
        logic [AW-1:0] e_rdaddr, e_wraddr;
        logic [DW-1:0] e_wdata;
        for (int i = 0; i < 256; i++) gold[i] = init_val(i);
        forever @(negedge clk) begin
            if (rst) begin
                if (wr_due >= cyc) gold[p_addr] = p_old;
                wr_due = -1;
                busy_until = 0;
                rsp_q.delete();
                due_q.delete();
                held = '0;
                chk("rst_ready", req_ready, 0);
                chk("rst_rden", mem_rden, 0);
                chk("rst_wren", mem_wren, 0);
                chk("rst_rsp_valid", rsp_valid, 0);
                chk("rst_rsp_rdata", rsp_rdata, 0);
            end else begin
                e_ready = cyc >= busy_until;
                {e_rden, e_wren, e_rdaddr, e_wraddr, e_wdata} = '0;
                if (wr_due == cyc) begin
                    e_wren = 1'b1;
                    e_wraddr = p_addr;
                    e_wdata = gold[p_addr];
                end
                if (req_valid && e_ready) begin
                    if (!req_we) begin
                        e_rden = 1'b1;
                        e_rdaddr = req_addr;
                        rsp_q.push_back(gold[req_addr]);
                        due_q.push_back(cyc + 2);
                        busy_until = cyc + 2;
                    end else if (req_be == 4'hF) begin
                        e_wren = 1'b1;
                        e_wraddr = req_addr;
                        e_wdata = req_wdata;
                        gold[req_addr] = req_wdata;
                    end else if (req_be != 4'h0) begin
                        e_rden = 1'b1;
                        e_rdaddr = req_addr;
                        p_addr = req_addr;
                        p_old = gold[req_addr];
                        gold[req_addr] = merge(p_old, req_wdata, req_be);
                        wr_due = cyc + 1;
                        busy_until = cyc + 2;
                    end
                end
                e_rsp = due_q.size() > 0 && due_q[0] == cyc;
                chk("req_ready", req_ready, e_ready);
                chk("mem_rden", mem_rden, e_rden);
                chk("mem_rdaddr", mem_rdaddr, e_rdaddr);
                chk("mem_wren", mem_wren, e_wren);
                chk("mem_wraddr", mem_wraddr, e_wraddr);
                chk("mem_wdata", mem_wdata, e_wdata);
                chk("rsp_valid", rsp_valid, e_rsp);
                if (e_rsp) begin
                    held = rsp_q.pop_front();
                    void'(due_q.pop_front());
                end
                chk("rsp_rdata", rsp_rdata, held);
            end
            if (mem_wren) begin wren_cnt++; cap_wdata = mem_wdata; end
            if (mem_rden) rden_cnt++;
            if (rsp_valid) begin rsp_cnt++; cap_rsp = rsp_rdata; end
            cyc++;
        end
    end

    // Present a request and keep it until accepted; returns 1 time unit after the accepting edge.
    task automatic do_req(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                          input logic [BW-1:0] be);
        logic acc = 1'b0;
        req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = d; req_be = be;
        for (int n = 0; n < 10 && !acc; n++) begin
            @(negedge clk);
            acc = req_ready;
            @(posedge clk);
            #1;
        end
        if (!acc) begin
            n_checks++;
            n_fail++;
            $display("FAIL handshake_timeout: req not accepted in 10 cycles, addr %h", a);
        end
    endtask

    task automatic idle(input int n);
        req_valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        int w0, r0, s0;
        logic [BW-1:0] be;
        #2 rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // full write then read back
        s0 = rsp_cnt;
        do_req(1, 5, 32'hDEADBEEF, 4'hF);
        do_req(0, 5, 0, 4'h0);
        idle(2);
        chk("full_rd_data", cap_rsp, 32'hDEADBEEF);
        chk("full_rsp_count", rsp_cnt - s0, 1);

        // partial write merges with stored word
        do_req(1, 7, 32'hAABBCCDD, 4'b0101);
        idle(1);
        chk("rmw_wdata", cap_wdata, 32'h11BB33DD);
        do_req(0, 7, 0, 4'h0);
        idle(2);
        chk("rmw_readback", cap_rsp, 32'h11BB33DD);

        // empty byte-enable does nothing
        w0 = wren_cnt; r0 = rden_cnt;
        do_req(1, 3, 32'hFFFFFFFF, 4'h0);
        idle(2);
        chk("be0_wren", wren_cnt - w0, 0);
        chk("be0_rden", rden_cnt - r0, 0);
        do_req(0, 3, 0, 4'h0);
        idle(2);
        chk("be0_readback", cap_rsp, 32'h0);

        // back-to-back full writes
        w0 = wren_cnt;
        for (int i = 0; i < 4; i++) do_req(1, AW'(i), 32'hC0DE0000 + i, 4'hF);
        idle(1);
        chk("b2b_wren", wren_cnt - w0, 4);

        // read then partial write then read, request held through busy cycles
        s0 = rsp_cnt;
        do_req(0, 2, 0, 4'h0);
        do_req(1, 2, 32'h99887766, 4'b1000);
        do_req(0, 2, 0, 4'h0);
        idle(3);
        chk("order_rsp_count", rsp_cnt - s0, 2);
        chk("order_last_rsp", cap_rsp, 32'h99DE0002);

        // reset in the merge cycle abandons the write
        do_req(1, 9, 32'hFFFFFFFF, 4'b0011);
        rst = 1'b1;
        req_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk("rst_target", ram[9], 32'h0BADF00D);
        s0 = rsp_cnt;
        do_req(0, 9, 0, 4'h0);
        idle(2);
        chk("rst_readback", cap_rsp, 32'h0BADF00D);
        chk("rst_rsp_count", rsp_cnt - s0, 1);

        // random traffic
        for (int k = 0; k < 300; k++) begin
            case ($urandom_range(0, 3))
                0: be = 4'h0;
                1: be = 4'hF;
                default: be = 4'($urandom_range(1, 14));
            endcase
            do_req(1'($urandom_range(0, 1)), AW'($urandom_range(0, 15)), $urandom, be);
            if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
        end
        idle(4);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
